lego_bgd_tile_scroller: RTL and testbench

Upstream address stage for the LEGO background brick bitmap. It maps every screen pixel onto a horizontally scrolling 32×15 grid of 32×32 bricks. It produces the in-tile `offsetX`/`offsetY` and `InsideRectangle` that the bitmap consumes, plus the tile coordinates used by collision logic. It also owns the brick-presence map, handles brick removal on hit, and reports when all bricks are cleared.

---
 rtl/lego_bgd_tile_scroller_if.sv | 35 +++
 rtl/lego_bgd_tile_scroller.sv | 99 +++++++++
 tb/tb_lego_bgd_tile_scroller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lego_bgd_tile_scroller_if.sv
// Pixel, scroll and brick-clear signals between the LEGO background tile
// scroller (slave) and its driver / consumers (master).
interface lego_bgd_tile_scroller_if;
    logic [10:0]       pixelX;
    logic [10:0]       pixelY;
    logic              startOfFrame;
    logic              scrollEnable;
    logic signed [5:0] scrollSpeed;
    logic              clearReq;
    logic [4:0]        clearCol;
    logic [3:0]        clearRow;
    logic              levelReset;
    logic [10:0]       offsetX;
    logic [10:0]       offsetY;
    logic              InsideRectangle;
    logic [4:0]        tileCol;
    logic [3:0]        tileRow;
    logic [9:0]        scrollX;
    logic [8:0]        brickCount;
    logic              allCleared;

    modport master (
        output pixelX, pixelY, startOfFrame, scrollEnable, scrollSpeed,
               clearReq, clearCol, clearRow, levelReset,
        input  offsetX, offsetY, InsideRectangle, tileCol, tileRow,
               scrollX, brickCount, allCleared
    );

    modport slave (
        input  pixelX, pixelY, startOfFrame, scrollEnable, scrollSpeed,
               clearReq, clearCol, clearRow, levelReset,
        output offsetX, offsetY, InsideRectangle, tileCol, tileRow,
               scrollX, brickCount, allCleared
    );
endinterface

// File: rtl/lego_bgd_tile_scroller.sv
// Maps screen pixels onto a horizontally scrolling 32x15 brick grid, owns the
// brick-presence map with hit removal, and reports when every brick is gone.
module lego_bgd_tile_scroller #(
    parameter int MAP_COLS  = 32,
    parameter int MAP_ROWS  = 15,
    parameter int SCREEN_W  = 640,
    parameter int ROW_FIRST = 2,
    parameter int ROW_LAST  = 5
) (
    input  logic                        clk,
    input  logic                        resetN,
    lego_bgd_tile_scroller_if.slave     bus
);
    localparam logic [10:0] SCREEN_W_L   = 11'(SCREEN_W);
    localparam logic [10:0] SCREEN_H_L   = 11'(MAP_ROWS * 32);
    localparam logic [3:0]  MAP_ROWS_L   = 4'(MAP_ROWS);
    localparam logic [8:0]  INIT_COUNT   = 9'(MAP_COLS * (ROW_LAST - ROW_FIRST + 1));

    // Scroll wraps modulo the 1024 px world in both directions.
    function automatic logic [9:0] wrap_scroll(input logic [9:0] cur,
                                               input logic signed [5:0] spd);
        logic [9:0] ext;
        ext = {{4{spd[5]}}, spd};
        return cur + ext;
    endfunction

    // A 16th row is kept permanently empty so any 4-bit row index is legal.
    logic [MAP_COLS-1:0] r_map [16];
    logic [9:0]          r_scrollX;
    logic [8:0]          r_brickCount;

    logic [10:0] w_sum;
    logic [9:0]  w_worldX;
    logic [4:0]  w_col;
    logic [3:0]  w_row;
    logic        w_inside;

    assign w_sum    = bus.pixelX + {1'b0, r_scrollX};
    assign w_worldX = w_sum[9:0];
    assign w_col    = w_worldX[9:5];
    assign w_row    = bus.pixelY[8:5];
    assign w_inside = (bus.pixelX < SCREEN_W_L) && (bus.pixelY < SCREEN_H_L) &&
                      r_map[w_row][w_col];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int r = 0; r < 16; r++)
                r_map[r] <= (r >= ROW_FIRST && r <= ROW_LAST) ? '1 : '0;
            r_scrollX    <= '0;
            r_brickCount <= INIT_COUNT;
        end else if (bus.levelReset) begin
            for (int r = 0; r < 16; r++)
                r_map[r] <= (r >= ROW_FIRST && r <= ROW_LAST) ? '1 : '0;
            r_scrollX    <= '0;
            r_brickCount <= INIT_COUNT;
        end else begin
            // Clearing an empty or out-of-range cell is a no-op, so repeat hits are harmless.
            if (bus.clearReq && (bus.clearRow < MAP_ROWS_L) &&
                r_map[bus.clearRow][bus.clearCol]) begin
                r_map[bus.clearRow][bus.clearCol] <= 1'b0;
                r_brickCount <= r_brickCount - 9'd1;
            end
            if (bus.startOfFrame && bus.scrollEnable)
                r_scrollX <= wrap_scroll(r_scrollX, bus.scrollSpeed);
        end
    end

    // Stage p1: registered pixel outputs, looked up with the pre-edge map and scroll.
    logic [4:0] r_offsetX_p1;
    logic [4:0] r_offsetY_p1;
    logic [4:0] r_tileCol_p1;
    logic [3:0] r_tileRow_p1;
    logic       r_inside_p1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_offsetX_p1 <= '0;
            r_offsetY_p1 <= '0;
            r_tileCol_p1 <= '0;
            r_tileRow_p1 <= '0;
            r_inside_p1  <= 1'b0;
        end else begin
            r_offsetX_p1 <= w_worldX[4:0];
            r_offsetY_p1 <= bus.pixelY[4:0];
            r_tileCol_p1 <= w_col;
            r_tileRow_p1 <= w_row;
            r_inside_p1  <= w_inside;
        end
    end

    assign bus.offsetX         = {6'd0, r_offsetX_p1};
    assign bus.offsetY         = {6'd0, r_offsetY_p1};
    assign bus.tileCol         = r_tileCol_p1;
    assign bus.tileRow         = r_tileRow_p1;
    assign bus.InsideRectangle = r_inside_p1;
    assign bus.scrollX         = r_scrollX;
    assign bus.brickCount      = r_brickCount;
    assign bus.allCleared      = (r_brickCount == 9'd0);
endmodule

// File: tb/tb_lego_bgd_tile_scroller.sv
// Self-checking bench for lego_bgd_tile_scroller: directed scenarios plus
// randomized traffic checked against a behavioural brick-world model.
module tb_lego_bgd_tile_scroller;
    logic clk;
    logic resetN;
    int   total;
    int   bad;

    lego_bgd_tile_scroller_if bus ();

    lego_bgd_tile_scroller dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural world model
    bit m_map [16][32];
    int m_scroll;
    int m_count;
    int e_offX, e_offY, e_col, e_row, e_in;

    task automatic model_init();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++)
                m_map[r][c] = (r >= 2 && r <= 5);
        m_scroll = 0;
        m_count  = 128;
    endtask

    task automatic idle_inputs();
        bus.startOfFrame = 1'b0;
        bus.scrollEnable = 1'b0;
        bus.scrollSpeed  = 6'sd0;
        bus.clearReq     = 1'b0;
        bus.clearCol     = 5'd0;
        bus.clearRow     = 4'd0;
        bus.levelReset   = 1'b0;
    endtask

    // One clock: predict pixel outputs from pre-edge state, advance model, step DUT.
    task automatic tick();
        int px, py, wx;
        px = int'(bus.pixelX);
        py = int'(bus.pixelY);
        wx = (px + m_scroll) % 1024;
        e_offX = wx % 32;
        e_col  = wx / 32;
        e_offY = py % 32;
        e_row  = (py / 32) % 16;
        e_in   = (px < 640 && py < 480) ? int'(m_map[py / 32][wx / 32]) : 0;
        if (bus.levelReset) begin
            model_init();
        end else begin
            if (bus.clearReq && int'(bus.clearRow) < 15 &&
                m_map[bus.clearRow][bus.clearCol]) begin
                m_map[bus.clearRow][bus.clearCol] = 1'b0;
                m_count--;
            end
            if (bus.startOfFrame && bus.scrollEnable)
                m_scroll = ((m_scroll + int'(bus.scrollSpeed)) % 1024 + 1024) % 1024;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_pixel(input int x, input int y);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
    endtask

    task automatic test_reset();
        idle_inputs();
        set_pixel(37, 70);
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_init();
        resetN = 1'b1;
        total++; if (bus.brickCount !== 9'd128) begin bad++; $display("FAIL reset_count got=%0d want=128", bus.brickCount); end
        total++; if (bus.scrollX !== 10'd0) begin bad++; $display("FAIL reset_scroll got=%0d want=0", bus.scrollX); end
        total++; if (bus.InsideRectangle !== 1'b0) begin bad++; $display("FAIL reset_inside got=%b want=0", bus.InsideRectangle); end
        total++; if (bus.allCleared !== 1'b0) begin bad++; $display("FAIL reset_allcleared got=%b want=0", bus.allCleared); end
        total++; if (bus.offsetX !== 11'd0 || bus.tileCol !== 5'd0) begin bad++; $display("FAIL reset_pixel offX=%0d col=%0d want=0,0", bus.offsetX, bus.tileCol); end
    endtask

    task automatic test_basic_mapping();
        set_pixel(37, 70);
        tick();
        total++; if (bus.offsetX !== 11'd5) begin bad++; $display("FAIL map_offx got=%0d want=5", bus.offsetX); end
        total++; if (bus.offsetY !== 11'd6) begin bad++; $display("FAIL map_offy got=%0d want=6", bus.offsetY); end
        total++; if (bus.tileCol !== 5'd1) begin bad++; $display("FAIL map_col got=%0d want=1", bus.tileCol); end
        total++; if (bus.tileRow !== 4'd2) begin bad++; $display("FAIL map_row got=%0d want=2", bus.tileRow); end
        total++; if (bus.InsideRectangle !== 1'b1) begin bad++; $display("FAIL map_inside got=%b want=1", bus.InsideRectangle); end
        set_pixel(37, 10);
        tick();
        total++; if (bus.InsideRectangle !== 1'b0) begin bad++; $display("FAIL map_empty_row got=%b want=0", bus.InsideRectangle); end
        set_pixel(700, 70);
        tick();
        total++; if (bus.InsideRectangle !== 1'b0) begin bad++; $display("FAIL map_offscreen got=%b want=0", bus.InsideRectangle); end
        total++; if (bus.tileCol !== 5'd21 || bus.offsetX !== 11'd28) begin bad++; $display("FAIL map_offscreen_coord col=%0d offx=%0d want=21,28", bus.tileCol, bus.offsetX); end
    endtask

    task automatic frame_scroll(input int spd);
        bus.scrollSpeed  = 6'(spd);
        bus.scrollEnable = 1'b1;
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic test_scroll_wrap();
        frame_scroll(-3);
        total++; if (bus.scrollX !== 10'd1021) begin bad++; $display("FAIL scroll_neg got=%0d want=1021", bus.scrollX); end
        set_pixel(10, 70);
        tick();
        total++; if (bus.offsetX !== 11'd7 || bus.tileCol !== 5'd0) begin bad++; $display("FAIL scroll_pixel offx=%0d col=%0d want=7,0", bus.offsetX, bus.tileCol); end
        bus.scrollEnable = 1'b0;
        bus.startOfFrame = 1'b1;
        bus.scrollSpeed  = 6'sd9;
        tick();
        bus.startOfFrame = 1'b0;
        total++; if (bus.scrollX !== 10'd1021) begin bad++; $display("FAIL scroll_disabled got=%0d want=1021", bus.scrollX); end
        frame_scroll(-21);
        total++; if (bus.scrollX !== 10'd1000) begin bad++; $display("FAIL scroll_to_1000 got=%0d want=1000", bus.scrollX); end
        frame_scroll(31);
        total++; if (bus.scrollX !== 10'd7) begin bad++; $display("FAIL scroll_pos_wrap got=%0d want=7", bus.scrollX); end
        idle_inputs();
    endtask

    task automatic do_clear(input int col, input int row);
        bus.clearReq = 1'b1;
        bus.clearCol = 5'(col);
        bus.clearRow = 4'(row);
        tick();
        bus.clearReq = 1'b0;
    endtask

    task automatic test_clear();
        bus.levelReset = 1'b1;
        tick();
        bus.levelReset = 1'b0;
        do_clear(1, 2);
        total++; if (bus.brickCount !== 9'd127) begin bad++; $display("FAIL clear_count got=%0d want=127", bus.brickCount); end
        set_pixel(37, 70);
        tick();
        total++; if (bus.InsideRectangle !== 1'b0) begin bad++; $display("FAIL clear_pixel got=%b want=0", bus.InsideRectangle); end
        do_clear(1, 2);
        total++; if (bus.brickCount !== 9'd127) begin bad++; $display("FAIL clear_dup got=%0d want=127", bus.brickCount); end
        do_clear(4, 15);
        total++; if (bus.brickCount !== 9'd127) begin bad++; $display("FAIL clear_row15 got=%0d want=127", bus.brickCount); end
        // Pixel sampled alongside the clear of its own tile still sees the brick.
        set_pixel(100, 80);
        do_clear(3, 2);
        total++; if (bus.InsideRectangle !== 1'b1) begin bad++; $display("FAIL clear_same_cycle got=%b want=1", bus.InsideRectangle); end
        tick();
        total++; if (bus.InsideRectangle !== 1'b0) begin bad++; $display("FAIL clear_next_cycle got=%b want=0", bus.InsideRectangle); end
        total++; if (bus.brickCount !== 9'd126) begin bad++; $display("FAIL clear_count2 got=%0d want=126", bus.brickCount); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_pixel($urandom_range(0, 1100), $urandom_range(0, 600));
            bus.startOfFrame = ($urandom_range(0, 7) == 0);
            bus.scrollEnable = ($urandom_range(0, 3) != 0);
            bus.scrollSpeed  = 6'($urandom_range(0, 63));
            bus.clearReq     = ($urandom_range(0, 2) == 0);
            bus.clearCol     = 5'($urandom_range(0, 31));
            bus.clearRow     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                            : 4'($urandom_range(2, 5));
            bus.levelReset   = ($urandom_range(0, 199) == 0);
            tick();
            total++; if (bus.offsetX !== 11'(e_offX) || bus.offsetY !== 11'(e_offY)) begin bad++; $display("FAIL rnd_offset i=%0d got=%0d,%0d want=%0d,%0d", i, bus.offsetX, bus.offsetY, e_offX, e_offY); end
            total++; if (bus.tileCol !== 5'(e_col) || bus.tileRow !== 4'(e_row)) begin bad++; $display("FAIL rnd_tile i=%0d got=%0d,%0d want=%0d,%0d", i, bus.tileCol, bus.tileRow, e_col, e_row); end
            total++; if (bus.InsideRectangle !== 1'(e_in)) begin bad++; $display("FAIL rnd_inside i=%0d got=%b want=%0d", i, bus.InsideRectangle, e_in); end
            total++; if (bus.scrollX !== 10'(m_scroll)) begin bad++; $display("FAIL rnd_scroll i=%0d got=%0d want=%0d", i, bus.scrollX, m_scroll); end
            total++; if (bus.brickCount !== 9'(m_count) || bus.allCleared !== (m_count == 0)) begin bad++; $display("FAIL rnd_count i=%0d got=%0d/%b want=%0d", i, bus.brickCount, bus.allCleared, m_count); end
        end
        idle_inputs();
    endtask

    task automatic test_full_clear();
        bus.levelReset = 1'b1;
        tick();
        bus.levelReset = 1'b0;
        for (int r = 2; r <= 5; r++) begin
            for (int c = 0; c < 32; c++) begin
                total++; if (bus.allCleared !== 1'b0) begin bad++; $display("FAIL full_early r=%0d c=%0d got=%b want=0", r, c, bus.allCleared); end
                do_clear(c, r);
            end
        end
        total++; if (bus.allCleared !== 1'b1 || bus.brickCount !== 9'd0) begin bad++; $display("FAIL full_cleared got=%b/%0d want=1/0", bus.allCleared, bus.brickCount); end
        frame_scroll(12);
        bus.levelReset   = 1'b1;
        bus.clearReq     = 1'b1;
        bus.clearCol     = 5'd7;
        bus.clearRow     = 4'd3;
        bus.startOfFrame = 1'b1;
        bus.scrollEnable = 1'b1;
        bus.scrollSpeed  = 6'sd5;
        tick();
        idle_inputs();
        total++; if (bus.brickCount !== 9'd128) begin bad++; $display("FAIL lvl_count got=%0d want=128", bus.brickCount); end
        total++; if (bus.scrollX !== 10'd0) begin bad++; $display("FAIL lvl_scroll got=%0d want=0", bus.scrollX); end
        total++; if (bus.allCleared !== 1'b0) begin bad++; $display("FAIL lvl_allcleared got=%b want=0", bus.allCleared); end
    endtask

    task automatic test_reset_mid();
        frame_scroll(17);
        set_pixel(200, 100);
        tick();
        bus.clearReq = 1'b1;
        bus.clearCol = 5'd9;
        bus.clearRow = 4'd4;
        #2;
        resetN = 1'b0;
        #1;
        total++; if (bus.scrollX !== 10'd0 || bus.brickCount !== 9'd128) begin bad++; $display("FAIL rmid_state scroll=%0d count=%0d want=0,128", bus.scrollX, bus.brickCount); end
        total++; if (bus.InsideRectangle !== 1'b0 || bus.offsetX !== 11'd0 || bus.offsetY !== 11'd0 || bus.tileRow !== 4'd0) begin bad++; $display("FAIL rmid_pixel in=%b offx=%0d offy=%0d row=%0d want=0", bus.InsideRectangle, bus.offsetX, bus.offsetY, bus.tileRow); end
        @(posedge clk);
        #1;
        total++; if (bus.brickCount !== 9'd128) begin bad++; $display("FAIL rmid_held got=%0d want=128", bus.brickCount); end
        idle_inputs();
        resetN = 1'b1;
        model_init();
        set_pixel(300, 130);
        tick();
        total++; if (bus.InsideRectangle !== 1'b1 || bus.tileCol !== 5'd9) begin bad++; $display("FAIL rmid_after in=%b col=%0d want=1,9", bus.InsideRectangle, bus.tileCol); end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        resetN = 1'b1;
        idle_inputs();
        set_pixel(0, 0);
        #2;
        test_reset();
        test_basic_mapping();
        test_scroll_wrap();
        test_clear();
        test_random();
        test_full_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
